// File: rtl/channel_bit_error_injector_if.sv
// Word-stream handshake bundle for the bit error injector.
// Upstream word in, corrupted word plus flip mask out.
interface channel_bit_error_injector_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic [DATA_W-1:0] out_err_mask;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_data,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  out_data,
    input  out_err_mask,
    input  out_valid
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output out_data,
    output out_err_mask,
    output out_valid
  );
endinterface

// File: rtl/channel_bit_error_injector.sv
// Bit-serial channel error injector driven by the channel state machine.
// One bit per cycle is flipped when the LFSR byte falls under err_prob.
module channel_bit_error_injector #(
  parameter int          DATA_W = 8,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [7:0]           err_prob,
  channel_bit_error_injector_if.slave bus,
  output logic [6:0]           rand_state,
  output logic                 state_adv,
  output logic [CNT_W-1:0]     err_count
);

  localparam int IW = $clog2(DATA_W);
  localparam logic [15:0] SEED_INIT =
    (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [1:0] {
    IDLE,
    CORRUPT,
    HOLD
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [15:0]       lfsr;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] mask;
  logic [IW-1:0]     idx;

  logic              accept;
  logic              last;
  logic              flip;
  logic              fb;
  logic [DATA_W-1:0] bit_vec;

  assign accept = bus.in_valid & bus.in_ready;
  assign last   = (idx == IW'(DATA_W - 1));
  assign fb     = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_comb begin
    flip    = enable & ((err_prob == 8'hFF) | (lfsr[7:0] < err_prob));
    bit_vec = '0;
    if (flip) bit_vec = DATA_W'(1) << idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = CORRUPT;
      CORRUPT: if (last) state_d = HOLD;
      HOLD:    if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == HOLD);
    state_adv     = (state_q == CORRUPT);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lfsr             <= SEED_INIT;
      shreg            <= '0;
      mask             <= '0;
      idx              <= '0;
      bus.out_data     <= '0;
      bus.out_err_mask <= '0;
      err_count        <= '0;
      rand_state       <= SEED[14:8];
    end else begin
      unique case (1'b1)
        accept: begin
          shreg <= bus.in_data;
          mask  <= '0;
          idx   <= '0;
        end
        state_adv: begin
          shreg      <= shreg ^ bit_vec;
          mask       <= mask | bit_vec;
          idx        <= idx + IW'(1);
          lfsr       <= {lfsr[14:0], fb};
          rand_state <= lfsr[14:8];
          if (flip && (err_count != {CNT_W{1'b1}}))
            err_count <= err_count + CNT_W'(1);
          // Final bit folds straight into the output registers.
          if (last) begin
            bus.out_data     <= shreg ^ bit_vec;
            bus.out_err_mask <= mask | bit_vec;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_bit_error_injector.sv
// Scoreboard bench for the channel bit error injector.
// A reference LFSR predicts every word, mask and counter value.
module tb_channel_bit_error_injector;

  localparam int          DW   = 8;
  localparam int          CW   = 4;
  localparam logic [15:0] SEED = 16'hACE1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [7:0]    err_prob = 8'h00;
  logic [6:0]    rand_state;
  logic          state_adv;
  logic [CW-1:0] err_count;

  channel_bit_error_injector_if #(.DATA_W(DW)) bus ();

  channel_bit_error_injector #(
    .DATA_W(DW),
    .CNT_W (CW),
    .SEED  (SEED)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .err_prob  (err_prob),
    .bus       (bus),
    .rand_state(rand_state),
    .state_adv (state_adv),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [DW-1:0] d;
    logic [DW-1:0] m;
    logic [CW-1:0] c;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          mon_e;
  logic [15:0]   m_lfsr;
  logic [CW-1:0] m_cnt;

  function automatic logic [15:0] step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out", 32'(bus.out_data), 32'hDEAD);
      end else begin
        mon_e = exp_q.pop_front();
        chk("out_data", 32'(bus.out_data), 32'(mon_e.d));
        chk("out_mask", 32'(bus.out_err_mask), 32'(mon_e.m));
        chk("err_count", 32'(err_count), 32'(mon_e.c));
      end
    end
  end

  task automatic send_word(input logic [DW-1:0] d,
                           input logic en,
                           input logic [7:0] p);
    int            n;
    int            adv;
    bit            early;
    bit            rs_ok;
    logic [6:0]    rs[DW];
    logic [DW-1:0] fm;
    exp_t          e;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      chk("ready_timeout", 32'(bus.in_ready), 32'd1);
      return;
    end
    enable = en;
    err_prob = p;
    bus.in_data = d;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    fm = '0;
    for (int i = 0; i < DW; i++) begin
      rs[i] = m_lfsr[14:8];
      if (en && (p == 8'hFF || m_lfsr[7:0] < p)) begin
        fm[i] = 1'b1;
        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
      end
      m_lfsr = step(m_lfsr);
    end
    e.d = d ^ fm;
    e.m = fm;
    e.c = m_cnt;
    exp_q.push_back(e);
    adv = 0;
    early = 1'b0;
    rs_ok = 1'b1;
    for (int k = 0; k < DW; k++) begin
      @(negedge clk);
      adv += int'(state_adv);
      if (bus.out_valid) early = 1'b1;
      if (k > 0 && rand_state !== rs[k-1]) rs_ok = 1'b0;
    end
    @(negedge clk);
    chk("adv_cycles", 32'(adv), 32'(DW));
    chk("valid_early", 32'(early), 32'd0);
    chk("rs_seq", 32'(rs_ok), 32'd1);
    chk("rs_last", 32'(rand_state), 32'(rs[DW-1]));
    chk("latency_valid", 32'(bus.out_valid), 32'd1);
    chk("adv_off", 32'(state_adv), 32'd0);
  endtask

  logic [7:0] probs[6] = '{8'h40, 8'h80, 8'h01, 8'hC0, 8'h20, 8'hFE};

  initial begin
    int n;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.out_ready = 1'b1;
    m_lfsr = SEED;
    m_cnt = '0;
    #12;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_data", 32'(bus.out_data), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_rand_state", 32'(rand_state), 32'(SEED[14:8]));
    chk("rst_state_adv", 32'(state_adv), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    send_word(8'hA5, 1'b1, 8'h00);
    send_word(8'hA5, 1'b1, 8'hFF);
    send_word(8'h3C, 1'b0, 8'hFF);
    send_word(8'h77, 1'b1, 8'hFF);
    send_word(8'h01, 1'b1, 8'hFF);
    for (int i = 0; i < 6; i++)
      send_word(DW'($urandom), 1'b1, probs[i]);

    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    send_word(8'hE1, 1'b1, 8'hFF);
    bus.in_data = 8'h11;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
      chk("hold_ready", 32'(bus.in_ready), 32'd0);
      chk("hold_data", 32'(bus.out_data), 32'(exp_q[0].d));
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("post_hold_ready", 32'(bus.in_ready), 32'd1);
    chk("post_hold_adv", 32'(state_adv), 32'd0);

    enable = 1'b1;
    err_prob = 8'h80;
    bus.in_data = 8'h96;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_count", 32'(err_count), 32'd0);
    chk("mid_rst_rs", 32'(rand_state), 32'(SEED[14:8]));
    m_lfsr = SEED;
    m_cnt = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    send_word(8'hC3, 1'b1, 8'h80);
    send_word(8'h0F, 1'b1, 8'hFF);

    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/channel_bit_error_injector.md
Name: channel_bit_error_injector

Overview:
- Downstream consumer of the two-state channel state machine.
- Takes the state machine's 8-bit error threshold and corrupts a data word bit-serially, one bit per cycle, using an internal LFSR.
- Feeds a 7-bit random value back to the state machine input so the channel state evolves once per processed bit.
- Sits between the transmitter word stream and the receiver decoder, with valid/ready handshakes on both sides.

Parameters:
- DATA_W, 8, word width in bits (2..32).
- CNT_W, 16, width of the saturating error counter.
- SEED, 16'hACE1, LFSR reset value; 0 is replaced by 16'h0001.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- enable  in  1  1 = inject errors; 0 = transparent pass (same latency, no flips).
- err_prob  in  8  flip threshold from the state machine's output_signal.
- in_data  in  DATA_W  word to corrupt.
- in_valid  in  1  in_data valid.
- in_ready  out  1  block can accept a word.
- out_data  out  DATA_W  corrupted word.
- out_err_mask  out  DATA_W  1 marks each flipped bit position.
- out_valid  out  1  out_data/out_err_mask valid.
- out_ready  in  1  downstream accepts the word.
- rand_state  out  7  random value to the state machine's input_signal.
- state_adv  out  1  one-cycle pulse per processed bit; gates the state machine's advance.
- err_count  out  CNT_W  total flipped bits, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; lfsr=SEED, or 1 if SEED==0.
  - in_ready=1 and out_valid=0.
  - out_data, out_err_mask, err_count and bit index are cleared to 0.
  - rand_state=SEED[14:8]; state_adv=0.
- FSM states IDLE, CORRUPT, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch in_data into the shift buffer, clear mask, set idx=0, go to CORRUPT.
- CORRUPT:
  - in_ready=0; lasts exactly DATA_W cycles, processing bit idx (LSB first).
  - Each cycle, r=lfsr[7:0], flip = enable & (err_prob==8'hFF | r < err_prob), unsigned compare. err_prob=0 never flips; 8'hFF always flips.
  - buf[idx] ^= flip; mask[idx]=flip; err_count += flip, saturating at all-ones.
  - state_adv=1 for this cycle; rand_state registered to lfsr[14:8] at the same edge.
  - LFSR advances each CORRUPT cycle only:
    - Fibonacci, shift left.
    - Feedback into bit0 = lfsr[15]^lfsr[13]^lfsr[12]^lfsr[10] (x^16+x^14+x^13+x^11+1).
  - After bit DATA_W-1, load out_data/out_err_mask from buffer, set out_valid=1, go to HOLD.
- HOLD:
  - out_valid=1 and outputs stable until out_ready=1.
  - The out_ready cycle completes the transfer: out_valid=0, next state IDLE.
  - in_ready stays 0 in HOLD; no bypass path.
- Latency: accept at edge N, out_valid high after edge N+DATA_W. Throughput is one word per DATA_W+2 cycles with out_ready held high.
- enable, err_prob: sampled every CORRUPT cycle, so a mid-word change applies from the next bit.
- rand_state: held constant outside CORRUPT.
- state_adv: 0 outside CORRUPT.
- in_valid outside IDLE: ignored; upstream must hold its word until in_ready.
- Reset asserted mid-word: the word is discarded with no output, and the LFSR reseeds.
- err_count: cleared only by reset.

Test Plan:
- enable=1, err_prob=0, in_data=8'hA5, out_ready=1 -> out_data=8'hA5, mask=8'h00, err_count=0, out_valid exactly 8 cycles after the accept edge, state_adv high 8 cycles.
- err_prob=8'hFF, in_data=8'hA5 -> out_data=8'h5A, mask=8'hFF, err_count=8.
- enable=0, err_prob=8'hFF, in_data=8'h3C -> out_data=8'h3C, mask=0, err_count unchanged; rand_state still updates each bit.
- CNT_W=4, err_prob=8'hFF, two back-to-back words -> err_count 8 then 15 (saturated, no wrap).
- err_prob=8'hFF, out_ready=0 for 5 cycles after out_valid -> out_valid/out_data held, in_ready=0; a second in_valid is not accepted until the cycle after the out_ready handshake.
- Drop reset low at bit 3 of a word -> in_ready=1 and out_valid=0 immediately (asynchronously); no output word; the next word's rand_state sequence matches the post-reset sequence from SEED.
